// File: rtl/gray_7seg_driver.sv
// gray_7seg_driver: Gray-to-binary converter with step/error flags and a
// multiplexed active-low hex display of the converted value.
module gray_7seg_driver #(
  parameter int N     = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] bin_out,
  output logic         step,
  output logic         gray_err,
  output logic [3:0]   an,
  output logic [6:0]   seg,
  output logic         dp
);
  localparam int ND = (N + 3) / 4;
  localparam int RW = $clog2(DIV);
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [N-1:0]  gray_q;
  logic [N-1:0]  disp;
  logic [N-1:0]  bin_d;
  logic [N-1:0]  diff;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [15:0]   disp_w;
  logic [3:0]    nib;
  logic          multi;
  logic          slot_end;
  logic          frame_end;
  logic          lit;
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < N; i++) bin_d[i] = ^(gray_in >> i);
  end
  // A change touching two or more bits leaves a nonzero result after clearing the lowest set bit.
  always_comb begin
    diff      = gray_in ^ gray_q;
    multi     = |(diff & (diff - 1'b1));
    slot_end  = rcnt == RW'(DIV - 1);
    frame_end = slot_end && idx == 2'(ND - 1);
    lit       = rcnt >= RW'(BLANK);
    disp_w    = 16'(disp);
    nib       = disp_w[{idx, 2'b00} +: 4];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_q   <= '0;
      bin_out  <= '0;
      step     <= 1'b0;
      gray_err <= 1'b0;
    end else begin
      gray_q   <= gray_in;
      bin_out  <= bin_d;
      step     <= gray_in != gray_q;
      gray_err <= gray_err | multi;
    end
  end
  // disp samples bin_out, so an input change on the latch cycle lands one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
      disp <= '0;
    end else begin
      rcnt <= slot_end ? '0 : rcnt + 1'b1;
      idx  <= slot_end ? (idx == 2'(ND - 1) ? 2'd0 : idx + 2'd1) : idx;
      disp <= frame_end ? bin_out : disp;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg <= lit ? FONT[nib] : 7'h7F;
      dp  <= ~(gray_err && lit && idx == 2'd0);
    end
  end
endmodule

// File: tb/tb_gray_7seg_driver.sv
// tb_gray_7seg_driver: scoreboard bench; expected outputs come from a
// cycle-indexed model of inputs since reset release.
module tb_gray_7seg_driver;
  localparam int N     = 8;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int ND    = (N + 3) / 4;
  localparam int F     = DIV * ND;
  localparam int MAXC  = 4096;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct packed {
    logic [N-1:0] bin;
    logic         step;
    logic         err;
    logic [3:0]   an;
    logic [6:0]   seg;
    logic         dp;
  } exp_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] gray_in = '0;
  logic [N-1:0] bin_out;
  logic         step;
  logic         gray_err;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp;
  exp_t         q [$];
  exp_t         me;
  int           checks = 0;
  int           failures = 0;
  int           k = 0;
  logic [N-1:0] gh [MAXC];
  bit           eh [MAXC];
  logic [N-1:0] cur;
  gray_7seg_driver #(.N(N), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .bin_out(bin_out),
    .step(step), .gray_err(gray_err), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  // Binary value whose Gray encoding equals g, found by search.
  function automatic logic [N-1:0] to_bin(input logic [N-1:0] g);
    for (int v = 0; v < 2 ** N; v++)
      if (N'(v ^ (v >> 1)) == g) return N'(v);
    return '0;
  endfunction
  task automatic drive(input bit r, input logic [N-1:0] g);
    exp_t         e;
    logic [N-1:0] prev;
    logic [N-1:0] dv;
    logic [3:0]   nib;
    int           rc, id, m;
    bit           lit, ep;
    @(negedge clk);
    reset   = r;
    gray_in = g;
    if (r) begin
      e = '{bin: '0, step: 1'b0, err: 1'b0, an: 4'hF, seg: 7'h7F, dp: 1'b1};
      k = 0;
    end else begin
      prev  = (k > 0) ? gh[k-1] : '0;
      ep    = (k > 0) ? eh[k-1] : 1'b0;
      gh[k] = g;
      eh[k] = ep || ($countones(g ^ prev) >= 2);
      rc    = k % DIV;
      id    = (k / DIV) % ND;
      m     = k / F;
      dv    = (m > 0) ? to_bin(gh[F*m-2]) : '0;
      nib   = 4'(dv >> (4 * id));
      lit   = rc >= BLANK;
      e.bin  = to_bin(g);
      e.step = g != prev;
      e.err  = eh[k];
      e.an   = lit ? ~(4'(1) << id) : 4'hF;
      e.seg  = lit ? FONT[nib] : 7'h7F;
      e.dp   = !(ep && lit && id == 0);
      k++;
    end
    q.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at t=%0t got=%0h expected=%0h", nm, $time, act, expv);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("bin_out", 32'(bin_out), 32'(me.bin));
      chk("step", 32'(step), 32'(me.step));
      chk("gray_err", 32'(gray_err), 32'(me.err));
      chk("an", 32'(an), 32'(me.an));
      chk("seg", 32'(seg), 32'(me.seg));
      chk("dp", 32'(dp), 32'(me.dp));
    end
  end
  initial begin
    repeat (3) drive(1'b1, '0);
    repeat (20) drive(1'b0, '0);
    repeat (40) drive(1'b0, 8'hC0);
    repeat (3) drive(1'b1, '0);
    repeat (5) drive(1'b0, 8'h00);
    repeat (10) drive(1'b0, 8'h01);
    repeat (40) drive(1'b0, 8'h02);
    repeat (2) drive(1'b1, '0);
    while (k != DIV + 3) drive(1'b0, 8'h5A);
    drive(1'b1, 8'h5A);
    repeat (40) drive(1'b0, 8'h5A);
    while (k % F != F - 1) drive(1'b0, 8'h33);
    repeat (2 * F + 2) drive(1'b0, 8'h77);
    cur = 8'h77;
    repeat (1500) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1 || k >= MAXC - 2) begin
        cur = '0;
        drive(1'b1, cur);
      end else if (r < 50) begin
        drive(1'b0, cur);
      end else if (r < 92) begin
        cur = cur ^ (N'(1) << $urandom_range(0, N - 1));
        drive(1'b0, cur);
      end else begin
        cur = N'($urandom);
        drive(1'b0, cur);
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
